div_clock_rx: RTL and testbench

Receiving end of the ripple clock divider. It accepts a divided clock, which is asynchronous to the 100 MHz system clock, and synchronizes it into the system domain. It emits one-cycle rising-edge and falling-edge tick pulses, measures the period in system-clock cycles, and reports lock and loss of the divided clock. Display-multiplex and scan logic consume `tick` as a clock enable instead of clocking flops from the divider output.

---
 rtl/div_clock_rx.sv | 177 +++++++++++++++++
 tb/tb_div_clock_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clock_rx.sv
// Synchronizes the divided clock into the system domain and produces rise/fall ticks,
// a period measurement, and lock / loss-of-clock status.
module div_clock_rx #(
   parameter int SYNC_STAGES  = 2,
   parameter int PERIOD_WIDTH = 20,
   parameter int LOCK_COUNT   = 4,
   parameter int TIMEOUT      = 262144
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    slow_in,
   output logic                    tick,
   output logic                    fall_tick,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic                    period_valid,
   output logic                    locked,
   output logic                    timeout
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

   localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_CNT = PERIOD_WIDTH'(TIMEOUT);
   localparam logic [MATCH_W-1:0]      LOCK_MATCH  = MATCH_W'(LOCK_COUNT);
   localparam logic [ARM_W-1:0]        ARM_LAST    = ARM_W'(SYNC_STAGES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEASURE,
      ST_LOCKED,
      ST_LOST
   } state_t;

   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    sync_last;
   logic                    hist_q;
   logic                    rise_evt;
   logic                    fall_evt;
   logic                    armed;
   logic [ARM_W-1:0]        arm_cnt;
   logic [PERIOD_WIDTH-1:0] cnt_q;
   logic [MATCH_W-1:0]      match_q;
   logic [MATCH_W-1:0]      match_d;
   state_t                  state_q;
   state_t                  state_d;
   logic                    load_period;
   logic                    valid_d;
   logic                    in_tol;
   logic                    timeout_hit;

   assign sync_last = sync_q[SYNC_STAGES-1];

   // Edge events are registered once more so every status update lands on the tick edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q   <= '0;
         hist_q   <= 1'b0;
         rise_evt <= 1'b0;
         fall_evt <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], slow_in};
         hist_q   <= sync_last;
         rise_evt <= armed & sync_last & ~hist_q;
         fall_evt <= armed & ~sync_last & hist_q;
      end
   end

   // Arming waits until the synchronizer holds only post-reset samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         arm_cnt <= '0;
         armed   <= 1'b0;
      end else if (!armed) begin
         if (arm_cnt == ARM_LAST) begin
            armed <= 1'b1;
         end else begin
            arm_cnt <= arm_cnt + 1'b1;
         end
      end
   end

   // Count starts at 1 on the tick edge so at the next tick it equals the edge distance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (!armed || rise_evt) begin
         cnt_q <= PERIOD_WIDTH'(1);
      end else if (cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign in_tol = ({1'b0, cnt_q} <= ({1'b0, period} + 1'b1)) &&
                   ({1'b0, period} <= ({1'b0, cnt_q} + 1'b1));
   assign timeout_hit = armed && (cnt_q >= TIMEOUT_CNT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A tick always takes priority over the timeout check in the same cycle.
   always_comb begin
      state_d     = state_q;
      match_d     = match_q;
      valid_d     = period_valid;
      load_period = 1'b0;
      case (state_q)
         ST_IDLE, ST_LOST: begin
            if (rise_evt) begin
               state_d = ST_MEASURE;
               match_d = '0;
            end else if (timeout_hit && state_q == ST_IDLE) begin
               state_d = ST_LOST;
               valid_d = 1'b0;
            end
         end
         ST_MEASURE: begin
            if (rise_evt) begin
               load_period = 1'b1;
               valid_d     = 1'b1;
               if (period_valid && in_tol) begin
                  match_d = match_q + 1'b1;
               end else begin
                  match_d = MATCH_W'(1);
               end
               if (match_d == LOCK_MATCH) begin
                  state_d = ST_LOCKED;
               end
            end else if (timeout_hit) begin
               state_d = ST_LOST;
               valid_d = 1'b0;
            end
         end
         ST_LOCKED: begin
            if (rise_evt) begin
               load_period = 1'b1;
               if (!in_tol) begin
                  state_d = ST_MEASURE;
                  match_d = MATCH_W'(1);
               end
            end else if (timeout_hit) begin
               state_d = ST_LOST;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick         <= 1'b0;
         fall_tick    <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         match_q      <= '0;
      end else begin
         tick         <= rise_evt;
         fall_tick    <= fall_evt;
         period_valid <= valid_d;
         match_q      <= match_d;
         if (load_period) begin
            period <= cnt_q;
         end
      end
   end

   assign locked  = (state_q == ST_LOCKED);
   assign timeout = (state_q == ST_LOST);

endmodule

// File: tb/tb_div_clock_rx.sv
// Bench for div_clock_rx: directed scenarios plus randomized divided-clock waveforms,
// checked every cycle against an edge-timeline model of the receiver.
module tb_div_clock_rx;

   localparam int SYNC_STAGES  = 2;
   localparam int PERIOD_WIDTH = 20;
   localparam int LOCK_COUNT   = 4;
   localparam int TIMEOUT      = 64;
   localparam int LAT          = SYNC_STAGES + 1;
   localparam int ARM_EDGE     = SYNC_STAGES + 1;
   localparam int FIRST_EDGE   = SYNC_STAGES + 3;
   localparam int MAXT         = 4096;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    slow_in = 1'b0;
   logic                    tick;
   logic                    fall_tick;
   logic [PERIOD_WIDTH-1:0] period;
   logic                    period_valid;
   logic                    locked;
   logic                    timeout;

   div_clock_rx #(
      .SYNC_STAGES (SYNC_STAGES),
      .PERIOD_WIDTH(PERIOD_WIDTH),
      .LOCK_COUNT  (LOCK_COUNT),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .slow_in     (slow_in),
      .tick        (tick),
      .fall_tick   (fall_tick),
      .period      (period),
      .period_valid(period_valid),
      .locked      (locked),
      .timeout     (timeout)
   );

   initial forever #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;
   int edge_cnt = 0;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check_output(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: edges counted from reset release, input sampled at each edge.
   int m_edge;
   bit m_samp[0:7];
   bit m_started;
   bit m_lost;
   int m_last;
   int m_periods[$];
   bit m_tick;
   bit m_fall;
   int m_period;

   function automatic int run_len();
      int n;
      if (m_periods.size() == 0) return 0;
      n = 1;
      for (int i = m_periods.size() - 1; i > 0; i--) begin
         if (m_periods[i] - m_periods[i-1] <= 1 && m_periods[i-1] - m_periods[i] <= 1) n++;
         else break;
      end
      return n;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_edge = 0;
         for (int i = 0; i < 8; i++) m_samp[i] = 1'b0;
         m_started = 1'b0;
         m_lost    = 1'b0;
         m_last    = 0;
         m_periods.delete();
         m_tick    = 1'b0;
         m_fall    = 1'b0;
         m_period  = 0;
      end else begin
         m_edge++;
         for (int i = 7; i > 0; i--) m_samp[i] = m_samp[i-1];
         m_samp[0] = slow_in;
         m_tick = (m_edge >= FIRST_EDGE) && m_samp[LAT] && !m_samp[LAT+1];
         m_fall = (m_edge >= FIRST_EDGE) && !m_samp[LAT] && m_samp[LAT+1];
         if (m_tick) begin
            if (!m_started) begin
               m_started = 1'b1;
               m_lost    = 1'b0;
            end else begin
               m_period = m_edge - m_last;
               m_periods.push_back(m_period);
               if (m_periods.size() > LOCK_COUNT) void'(m_periods.pop_front());
            end
            m_last = m_edge;
         end else if (!m_lost && (m_edge - (m_started ? m_last : ARM_EDGE)) >= TIMEOUT) begin
            m_lost    = 1'b1;
            m_started = 1'b0;
            m_periods.delete();
         end
      end
   end

   always @(negedge clock) begin
      check_output("tick", int'(tick), int'(m_tick));
      check_output("fall_tick", int'(fall_tick), int'(m_fall));
      check_output("period", int'(period), m_period);
      check_output("period_valid", int'(period_valid), int'(m_periods.size() > 0));
      check_output("locked", int'(locked), int'(run_len() >= LOCK_COUNT));
      check_output("timeout", int'(timeout), int'(m_lost));
   end

   // Per-tick snapshots used by the hand-computed scenario checks.
   int tick_num = 0;
   int tick_edge_at[MAXT];
   int lock_at[MAXT];
   int per_at[MAXT];
   int val_at[MAXT];
   int tmo_at[MAXT];
   int tmo_cycles = 0;
   int tmo_rise_edge = -1;
   bit prev_tmo = 1'b0;

   always @(negedge clock) begin
      if (tick) begin
         tick_num++;
         if (tick_num < MAXT) begin
            tick_edge_at[tick_num] = edge_cnt;
            lock_at[tick_num]      = int'(locked);
            per_at[tick_num]       = int'(period);
            val_at[tick_num]       = int'(period_valid);
            tmo_at[tick_num]       = int'(timeout);
         end
      end
      if (timeout) begin
         tmo_cycles++;
         if (!prev_tmo) tmo_rise_edge = edge_cnt;
      end
      prev_tmo = timeout;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_output("rst_tick", int'(tick), 0);
      check_output("rst_fall_tick", int'(fall_tick), 0);
      check_output("rst_period", int'(period), 0);
      check_output("rst_period_valid", int'(period_valid), 0);
      check_output("rst_locked", int'(locked), 0);
      check_output("rst_timeout", int'(timeout), 0);
      step(2);
      reset = 1'b1;
   endtask

   task automatic rise_then(input int hi, input int per);
      slow_in = 1'b1;
      step(hi);
      slow_in = 1'b0;
      step(per - hi);
   endtask

   task automatic apply_stimulus(input int segs);
      int k;
      int b;
      int hi;
      int lo;
      for (int s = 0; s < segs; s++) begin
         k = int'($urandom_range(0, 9));
         if (k == 0) begin
            do_reset();
            step(int'($urandom_range(1, 6)));
         end else if (k <= 2) begin
            slow_in = 1'($urandom_range(0, 1));
            step(int'($urandom_range(40, 120)));
         end else if (k <= 5) begin
            repeat ($urandom_range(3, 8)) begin
               hi = int'($urandom_range(3, 20));
               lo = int'($urandom_range(3, 20));
               rise_then(hi, hi + lo);
            end
         end else begin
            b = int'($urandom_range(10, 40));
            repeat ($urandom_range(4, 9)) rise_then(b / 2, b + int'($urandom_range(0, 2)) - 1);
         end
      end
   endtask

   int base;
   int rise_edge;
   int tmo0;
   int jp[7];

   initial begin
      @(posedge clock);
      #2;
      do_reset();
      step(4);

      // 8 high / 8 low square wave from IDLE
      base = tick_num;
      rise_edge = edge_cnt + 1;
      repeat (7) rise_then(8, 16);
      check_output("sq_tick_count", tick_num - base, 7);
      check_output("sq_first_latency", tick_edge_at[base+1] - rise_edge, 3);
      check_output("sq_t1_valid", val_at[base+1], 0);
      check_output("sq_t2_period", per_at[base+2], 16);
      check_output("sq_t2_valid", val_at[base+2], 1);
      check_output("sq_t4_locked", lock_at[base+4], 0);
      check_output("sq_t5_locked", lock_at[base+5], 1);

      // Input stops after lock
      step(80);
      check_output("to_delay", tmo_rise_edge - tick_edge_at[base+7], 64);
      check_output("to_timeout", int'(timeout), 1);
      check_output("to_locked", int'(locked), 0);
      check_output("to_valid", int'(period_valid), 0);
      check_output("to_period_held", int'(period), 16);
      base = tick_num;
      repeat (3) rise_then(8, 16);
      check_output("to_t1_timeout", tmo_at[base+1], 0);
      check_output("to_t1_valid", val_at[base+1], 0);
      check_output("to_t2_period", per_at[base+2], 16);
      check_output("to_t2_valid", val_at[base+2], 1);

      // Jittered periods then an out-of-tolerance one
      do_reset();
      step(4);
      jp = '{16, 17, 16, 15, 16, 20, 16};
      base = tick_num;
      foreach (jp[i]) rise_then(8, jp[i]);
      check_output("jit_tick_count", tick_num - base, 7);
      check_output("jit_t5_locked", lock_at[base+5], 1);
      check_output("jit_t6_locked", lock_at[base+6], 1);
      check_output("jit_t7_locked", lock_at[base+7], 0);
      check_output("jit_t7_period", per_at[base+7], 20);

      // slow_in already high across reset release
      slow_in = 1'b1;
      do_reset();
      base = tick_num;
      step(20);
      check_output("hi_rst_no_tick", tick_num - base, 0);
      slow_in = 1'b0;
      step(8);
      rise_then(8, 16);
      check_output("hi_rst_one_tick", tick_num - base, 1);

      // Reset while locked, then relock
      repeat (6) rise_then(8, 16);
      check_output("mid_locked_before", int'(locked), 1);
      do_reset();
      step(4);
      base = tick_num;
      repeat (6) rise_then(8, 16);
      check_output("mid_t4_locked", lock_at[base+4], 0);
      check_output("mid_t5_locked", lock_at[base+5], 1);

      // Tick period equal to TIMEOUT: tick wins every time
      do_reset();
      step(4);
      tmo0 = tmo_cycles;
      base = tick_num;
      repeat (8) rise_then(32, 64);
      check_output("sim_no_timeout", tmo_cycles - tmo0, 0);
      check_output("sim_t8_period", per_at[base+8], 64);
      check_output("sim_t8_locked", lock_at[base+8], 1);

      apply_stimulus(30);
      step(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
